// File: rtl/vga_pixel_engine.sv
// Parametrised VGA scan-out: raster timing, framebuffer word fetch, pixel unpack
// and a writable palette in one 3-stage pixel-clock pipeline.
module vga_pixel_engine #(
  parameter int H_VIS    = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_VIS    = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int BPP      = 4,
  parameter int WORD_W   = 32,
  parameter int ADDR_W   = 18,
  parameter int SYNC_ACT = 0
) (
  input  logic              pixelClk,
  input  logic              reset_n,
  input  logic              scale2x,
  output logic [ADDR_W-1:0] fb_addr,
  output logic              fb_en,
  input  logic [WORD_W-1:0] fb_data,
  input  logic              pal_we,
  input  logic [BPP-1:0]    pal_addr,
  input  logic [11:0]       pal_data,
  output logic              hSync,
  output logic              vSync,
  output logic              de,
  output logic [3:0]        VGA_R,
  output logic [3:0]        VGA_G,
  output logic [3:0]        VGA_B,
  output logic              frameStart
);
  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT + 1);
  localparam int VW    = $clog2(V_TOT + 1);
  localparam int PPW   = WORD_W / BPP;
  localparam int SUB_W = (PPW > 1) ? $clog2(PPW) : 1;

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_VIS_C    = HW'(H_VIS);
  localparam logic [HW-1:0] H_VIS_LAST = HW'(H_VIS - 1);
  localparam logic [HW-1:0] HS_BEG     = HW'(H_VIS + H_FP);
  localparam logic [HW-1:0] HS_END     = HW'(H_VIS + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_VIS_C    = VW'(V_VIS);
  localparam logic [VW-1:0] VS_BEG     = VW'(V_VIS + V_FP);
  localparam logic [VW-1:0] VS_END     = VW'(V_VIS + V_FP + V_SYNC);
  localparam logic [SUB_W-1:0]  SUB_LAST = SUB_W'(PPW - 1);
  localparam logic [ADDR_W-1:0] WPL_N    = ADDR_W'((H_VIS + PPW - 1) / PPW);
  localparam logic [ADDR_W-1:0] WPL_S    = ADDR_W'((H_VIS / 2 + PPW - 1) / PPW);
  localparam logic              SA       = 1'(SYNC_ACT);

  typedef struct packed {
    logic             hs;
    logic             vs;
    logic             vis;
    logic             fs;
    logic             load;
    logic [SUB_W-1:0] sub;
  } ctl_t;

  localparam ctl_t CTL_RST = '{hs: ~SA, vs: ~SA, vis: 1'b0, fs: 1'b0, load: 1'b0, sub: '0};

  logic [HW-1:0]     hcnt;
  logic [VW-1:0]     vcnt;
  logic [SUB_W-1:0]  sub_cnt;
  logic              scale_q;
  logic [ADDR_W-1:0] line_base, word_ptr;
  ctl_t              c1, c2;
  logic [WORD_W-1:0] held_word;
  logic [11:0]       pal [2**BPP];

  logic              h_vis, v_vis, in_vis, frame_top, scale_now, src_step, fetch;
  logic              hs_now, vs_now;
  logic [ADDR_W-1:0] addr_now;
  logic [WORD_W-1:0] cur_word;
  logic [BPP-1:0]    pix_idx;

  assign h_vis     = hcnt < H_VIS_C;
  assign v_vis     = vcnt < V_VIS_C;
  assign in_vis    = h_vis && v_vis;
  assign frame_top = (hcnt == '0) && (vcnt == '0);
  // scale2x is latched at the top of the frame; the top pixel itself already uses the new value
  assign scale_now = frame_top ? scale2x : scale_q;
  assign src_step  = !scale_now || hcnt[0];
  assign fetch     = in_vis && (sub_cnt == '0) && (!scale_now || !hcnt[0]);
  assign addr_now  = (hcnt == '0) ? line_base : word_ptr;
  assign hs_now    = (hcnt >= HS_BEG && hcnt < HS_END) ? SA : ~SA;
  assign vs_now    = (vcnt >= VS_BEG && vcnt < VS_END) ? SA : ~SA;

  always_ff @(posedge pixelClk or negedge reset_n) begin
    if (!reset_n) begin
      hcnt      <= '0;
      vcnt      <= '0;
      sub_cnt   <= '0;
      scale_q   <= 1'b0;
      line_base <= '0;
      word_ptr  <= '0;
    end else begin
      if (hcnt == H_LAST) begin
        hcnt <= '0;
        vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
      end else begin
        hcnt <= hcnt + 1'b1;
      end
      if (hcnt == H_LAST)
        sub_cnt <= '0;
      else if (src_step)
        sub_cnt <= (sub_cnt == SUB_LAST) ? '0 : sub_cnt + 1'b1;
      if (frame_top)
        scale_q <= scale2x;
      // in 2x mode even lines are shown twice, so the base only advances after odd lines
      if (hcnt == H_LAST && vcnt == V_LAST)
        line_base <= '0;
      else if (hcnt == H_VIS_LAST && v_vis && !(scale_now && !vcnt[0]))
        line_base <= line_base + (scale_now ? WPL_S : WPL_N);
      if (fetch)
        word_ptr <= addr_now + 1'b1;
    end
  end

  always_ff @(posedge pixelClk or negedge reset_n) begin
    if (!reset_n) begin
      fb_en   <= 1'b0;
      fb_addr <= '0;
      c1      <= CTL_RST;
    end else begin
      fb_en <= fetch;
      if (fetch)
        fb_addr <= addr_now;
      c1 <= '{hs: hs_now, vs: vs_now, vis: in_vis, fs: frame_top, load: fetch, sub: sub_cnt};
    end
  end

  assign cur_word = c2.load ? fb_data : held_word;
  assign pix_idx  = cur_word[WORD_W - 1 - BPP * int'(c2.sub) -: BPP];

  always_ff @(posedge pixelClk or negedge reset_n) begin
    if (!reset_n) begin
      c2         <= CTL_RST;
      held_word  <= '0;
      hSync      <= ~SA;
      vSync      <= ~SA;
      de         <= 1'b0;
      frameStart <= 1'b0;
      {VGA_R, VGA_G, VGA_B} <= 12'h000;
    end else begin
      c2         <= c1;
      held_word  <= cur_word;
      hSync      <= c2.hs;
      vSync      <= c2.vs;
      de         <= c2.vis;
      frameStart <= c2.fs;
      {VGA_R, VGA_G, VGA_B} <= c2.vis ? pal[pix_idx] : 12'h000;
    end
  end

  // no reset: the CPU reloads the palette; a same-cycle read sees the old entry
  always_ff @(posedge pixelClk) begin
    if (pal_we)
      pal[pal_addr] <= pal_data;
  end
endmodule

// File: tb/tb_vga_pixel_engine.sv
// Bench for vga_pixel_engine on a reduced raster: a per-cycle scoreboard driven
// by a frame-position model, plus scenario tasks with targeted checks.
module tb_vga_pixel_engine;
  localparam int H_VIS = 20, H_FP = 2, H_SYNC = 3, H_BP = 3;
  localparam int V_VIS = 6, V_FP = 1, V_SYNC = 2, V_BP = 1;
  localparam int BPP = 4, WORD_W = 32, ADDR_W = 10, SYNC_ACT = 0;
  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int FRAME = H_TOT * V_TOT;
  localparam int PPW = WORD_W / BPP;
  localparam int WPL_N = (H_VIS + PPW - 1) / PPW;
  localparam int WPL_S = (H_VIS / 2 + PPW - 1) / PPW;
  localparam logic SA = 1'b0;

  logic              pixelClk = 1'b0, reset_n = 1'b0, scale2x = 1'b0;
  logic [ADDR_W-1:0] fb_addr;
  logic              fb_en;
  logic [WORD_W-1:0] fb_data;
  logic              pal_we = 1'b0;
  logic [BPP-1:0]    pal_addr = '0;
  logic [11:0]       pal_data = '0;
  logic              hSync, vSync, de, frameStart;
  logic [3:0]        VGA_R, VGA_G, VGA_B;

  logic [WORD_W-1:0] mem [1<<ADDR_W];
  logic [11:0]       pal_model [1<<BPP];
  logic [11:0]       pal_before [1<<BPP];
  logic              scale_hist [8];
  logic [ADDR_W-1:0] exp_addr;
  logic              mon_en = 1'b0;
  int                k, checks, errors;

  vga_pixel_engine #(
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .BPP(BPP), .WORD_W(WORD_W), .ADDR_W(ADDR_W), .SYNC_ACT(SYNC_ACT)
  ) dut (
    .pixelClk(pixelClk), .reset_n(reset_n), .scale2x(scale2x),
    .fb_addr(fb_addr), .fb_en(fb_en), .fb_data(fb_data),
    .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
    .hSync(hSync), .vSync(vSync), .de(de),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .frameStart(frameStart)
  );

  always #5 pixelClk = ~pixelClk;

  // 1-cycle-latency BRAM
  always @(posedge pixelClk) if (fb_en) fb_data <= mem[fb_addr];

  // palette as seen by a lookup at this edge (before this edge's write)
  always @(posedge pixelClk) begin
    pal_before = pal_model;
    if (pal_we) pal_model[pal_addr] = pal_data;
  end

  function automatic void model(input int p, output logic vis, output logic hs, output logic vs,
                                output logic fs, output logic fe, output int addr,
                                output logic [11:0] rgb);
    int h, v, sx, sl, idx;
    logic sc;
    logic [WORD_W-1:0] w;
    h   = p % H_TOT;
    v   = (p / H_TOT) % V_TOT;
    sc  = scale_hist[(p / FRAME) % 8];
    vis = (h < H_VIS) && (v < V_VIS);
    hs  = (h >= H_VIS + H_FP && h < H_VIS + H_FP + H_SYNC) ? SA : !SA;
    vs  = (v >= V_VIS + V_FP && v < V_VIS + V_FP + V_SYNC) ? SA : !SA;
    fs  = (h == 0) && (v == 0);
    sx  = sc ? h / 2 : h;
    sl  = sc ? v / 2 : v;
    fe  = vis && (sx % PPW == 0) && (!sc || h % 2 == 0);
    addr = sl * (sc ? WPL_S : WPL_N) + sx / PPW;
    w   = mem[addr % (1 << ADDR_W)];
    idx = int'(w >> ((PPW - 1 - sx % PPW) * BPP)) & ((1 << BPP) - 1);
    rgb = vis ? pal_before[idx] : 12'h000;
  endfunction

  // scoreboard: after edge k, fetch outputs reflect position k-1, video outputs k-3
  always @(negedge pixelClk) begin : mon
    logic vis, hs, vs, fs, fe;
    int ad;
    logic [11:0] rgb;
    if (mon_en) begin
      model(k - 1, vis, hs, vs, fs, fe, ad, rgb);
      if (fe) exp_addr = ADDR_W'(ad);
      checks++;
      if (fb_en !== fe) begin
        errors++; $display("FAIL mon_fb_en k=%0d got=%0b exp=%0b", k, fb_en, fe);
      end
      checks++;
      if (fb_addr !== exp_addr) begin
        errors++; $display("FAIL mon_fb_addr k=%0d got=%0d exp=%0d", k, fb_addr, exp_addr);
      end
      if (k >= 3) model(k - 3, vis, hs, vs, fs, fe, ad, rgb);
      else begin vis = 1'b0; hs = !SA; vs = !SA; fs = 1'b0; rgb = 12'h000; end
      checks++;
      if ({hSync, vSync, de, frameStart} !== {hs, vs, vis, fs}) begin
        errors++;
        $display("FAIL mon_ctl k=%0d got=%b exp=%b", k, {hSync, vSync, de, frameStart}, {hs, vs, vis, fs});
      end
      checks++;
      if ({VGA_R, VGA_G, VGA_B} !== rgb) begin
        errors++; $display("FAIL mon_rgb k=%0d got=%03h exp=%03h", k, {VGA_R, VGA_G, VGA_B}, rgb);
      end
    end
  end

  task automatic step();
    if (k % FRAME == 0) scale_hist[(k / FRAME) % 8] = scale2x;
    @(posedge pixelClk);
    k++;
    @(negedge pixelClk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = $urandom;
    mem[0] = 32'h0123_4567;
    for (int i = 0; i < (1 << BPP); i++) begin
      @(negedge pixelClk);
      pal_we = 1'b1; pal_addr = BPP'(i); pal_data = {BPP'(i), BPP'(i), BPP'(i)};
    end
    @(negedge pixelClk);
    pal_we = 1'b0;
    checks++; if (hSync !== !SA) begin errors++; $display("FAIL rst_hsync got=%b exp=%b", hSync, !SA); end
    checks++; if (vSync !== !SA) begin errors++; $display("FAIL rst_vsync got=%b exp=%b", vSync, !SA); end
    checks++; if (de !== 1'b0) begin errors++; $display("FAIL rst_de got=%b exp=0", de); end
    checks++; if (frameStart !== 1'b0) begin errors++; $display("FAIL rst_fs got=%b exp=0", frameStart); end
    checks++; if (fb_en !== 1'b0) begin errors++; $display("FAIL rst_fb_en got=%b exp=0", fb_en); end
    checks++; if (fb_addr !== '0) begin errors++; $display("FAIL rst_fb_addr got=%0d exp=0", fb_addr); end
    checks++;
    if ({VGA_R, VGA_G, VGA_B} !== 12'h000) begin
      errors++; $display("FAIL rst_rgb got=%03h exp=000", {VGA_R, VGA_G, VGA_B});
    end
    #1 reset_n = 1'b1;
    k = 0; exp_addr = '0; mon_en = 1'b1;
  endtask

  task automatic test_frame();
    int q, r, de_n, fs_n, hs_n, fe_n, fe4;
    logic [ADDR_W-1:0] last_a, line1_a;
    de_n = 0; fs_n = 0; hs_n = 0; fe_n = 0; fe4 = 0; last_a = '0; line1_a = '1;
    repeat (FRAME) begin
      if (k == 100) scale2x = 1'b1;
      step();
      q = k - 3; r = k - 1;
      if (q >= 0 && q < 8) begin
        checks++;
        if ({VGA_R, VGA_G, VGA_B} !== {q[3:0], q[3:0], q[3:0]}) begin
          errors++; $display("FAIL unpack px=%0d got=%03h exp=%03h", q, {VGA_R, VGA_G, VGA_B}, {q[3:0], q[3:0], q[3:0]});
        end
      end
      de_n += int'(de); fs_n += int'(frameStart); hs_n += int'(hSync == SA);
      if (fb_en) begin
        fe_n++; last_a = fb_addr;
        if (r == H_TOT) line1_a = fb_addr;
        if (r / H_TOT == 4) fe4++;
      end
    end
    checks++; if (de_n != H_VIS * V_VIS) begin errors++; $display("FAIL de_count got=%0d exp=%0d", de_n, H_VIS * V_VIS); end
    checks++; if (fs_n != 1) begin errors++; $display("FAIL fs_count got=%0d exp=1", fs_n); end
    checks++; if (hs_n != H_SYNC * V_TOT) begin errors++; $display("FAIL hs_count got=%0d exp=%0d", hs_n, H_SYNC * V_TOT); end
    checks++; if (fe_n != V_VIS * WPL_N) begin errors++; $display("FAIL fetch_count got=%0d exp=%0d", fe_n, V_VIS * WPL_N); end
    checks++; if (last_a != ADDR_W'(V_VIS * WPL_N - 1)) begin errors++; $display("FAIL last_word got=%0d exp=%0d", last_a, V_VIS * WPL_N - 1); end
    checks++; if (line1_a != ADDR_W'(WPL_N)) begin errors++; $display("FAIL line1_addr got=%0d exp=%0d", line1_a, WPL_N); end
    checks++; if (fe4 != WPL_N) begin errors++; $display("FAIL midframe_scale got=%0d exp=%0d", fe4, WPL_N); end
  endtask

  task automatic test_scale2x();
    int r, fe0, de_n;
    logic seen16;
    logic [ADDR_W-1:0] first_a [3];
    int exp_first [3];
    fe0 = 0; de_n = 0; seen16 = 1'b0;
    exp_first[0] = 0; exp_first[1] = 0; exp_first[2] = WPL_S;
    for (int i = 0; i < 3; i++) first_a[i] = '1;
    repeat (FRAME) begin
      if (k == FRAME + 100) scale2x = 1'b0;
      step();
      r = k - 1 - FRAME;
      de_n += int'(de);
      if (fb_en) begin
        if (r / H_TOT == 0) fe0++;
        if (r == 16) seen16 = 1'b1;
        if (r % H_TOT == 0 && r / H_TOT < 3) first_a[r / H_TOT] = fb_addr;
      end
    end
    checks++; if (fe0 != WPL_S) begin errors++; $display("FAIL s2x_fetch_count got=%0d exp=%0d", fe0, WPL_S); end
    checks++; if (seen16 !== 1'b1) begin errors++; $display("FAIL s2x_fetch_at16 got=%b exp=1", seen16); end
    checks++; if (de_n != H_VIS * V_VIS) begin errors++; $display("FAIL s2x_de_count got=%0d exp=%0d", de_n, H_VIS * V_VIS); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (first_a[i] != ADDR_W'(exp_first[i])) begin
        errors++; $display("FAIL s2x_line%0d_addr got=%0d exp=%0d", i, first_a[i], exp_first[i]);
      end
    end
  endtask

  task automatic test_palette();
    mem[0] = 32'h0000_0550;
    while (k < 2 * FRAME + 7) step();
    pal_we = 1'b1; pal_addr = 4'd5; pal_data = 12'hF00;
    step();
    pal_we = 1'b0;
    checks++;
    if ({VGA_R, VGA_G, VGA_B} !== 12'h555) begin
      errors++; $display("FAIL pal_same_cycle got=%03h exp=555", {VGA_R, VGA_G, VGA_B});
    end
    step();
    checks++;
    if ({VGA_R, VGA_G, VGA_B} !== 12'hF00) begin
      errors++; $display("FAIL pal_next_cycle got=%03h exp=f00", {VGA_R, VGA_G, VGA_B});
    end
    while (k < 2 * FRAME + 3 + H_VIS) step();
    checks++;
    if ({de, VGA_R, VGA_G, VGA_B} !== 13'h0) begin
      errors++; $display("FAIL pal_blank got=%04h exp=0000", {de, VGA_R, VGA_G, VGA_B});
    end
  endtask

  task automatic test_reset_midline();
    while (k < 2 * FRAME + 2 * H_TOT + 10) step();
    #1 reset_n = 1'b0; mon_en = 1'b0;
    #1;
    checks++;
    if ({hSync, vSync, de, frameStart, fb_en} !== {!SA, !SA, 3'b000}) begin
      errors++; $display("FAIL midrst_ctl got=%b exp=%b", {hSync, vSync, de, frameStart, fb_en}, {!SA, !SA, 3'b000});
    end
    checks++;
    if (fb_addr !== '0) begin errors++; $display("FAIL midrst_fb_addr got=%0d exp=0", fb_addr); end
    checks++;
    if ({VGA_R, VGA_G, VGA_B} !== 12'h000) begin
      errors++; $display("FAIL midrst_rgb got=%03h exp=000", {VGA_R, VGA_G, VGA_B});
    end
    repeat (3) @(negedge pixelClk);
    #1 reset_n = 1'b1;
    k = 0; exp_addr = '0; mon_en = 1'b1;
    step();
    checks++;
    if ({fb_en, fb_addr} !== {1'b1, ADDR_W'(0)}) begin
      errors++; $display("FAIL restart_fetch got=%b/%0d exp=1/0", fb_en, fb_addr);
    end
    step(); step();
    checks++;
    if ({frameStart, de} !== 2'b11) begin
      errors++; $display("FAIL restart_fs got=%b exp=11", {frameStart, de});
    end
    repeat (2 * H_TOT + 5) step();
  endtask

  initial begin
    checks = 0; errors = 0; k = 0; exp_addr = '0;
    test_reset();
    test_frame();
    test_scale2x();
    test_palette();
    test_reset_midline();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
